// File: rtl/tdm_transmit.sv
// TDM serial transmitter: divides clk_in down to a bit clock, frames
// SLOTS left-justified samples per frame with a one-bit-period frame sync,
// and double-buffers one frame so the producer can hand over the next frame
// while the current one is shifting out.
module tdm_transmit #(
    parameter int SLOTS               = 4,
    parameter int SLOT_BITS           = 32,
    parameter int SAMPLE_BITS         = 24,
    parameter int CYCLES_PER_HALF_SCK = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [SAMPLE_BITS-1:0] audio_in [SLOTS],
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic                   sck_out,
    output logic                   ws_out,
    output logic                   sd_out,
    output logic                   frame_start_out,
    output logic                   underrun_out
);

    localparam int FRAME_BITS = SLOTS * SLOT_BITS;
    localparam int CW         = $clog2(CYCLES_PER_HALF_SCK);
    localparam int BW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] DIV_LAST = CW'(CYCLES_PER_HALF_SCK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    logic [CW-1:0]         div_q;
    logic                  sck_q;
    logic [BW-1:0]         bit_q;
    logic [BW-1:0]         bit_d;
    logic                  ws_q;
    logic                  sd_q;
    logic [FRAME_BITS-1:0] sh_q;
    logic [FRAME_BITS-1:0] buf_q;
    logic                  full_q;
    logic                  fs_q;
    logic                  ur_q;

    logic                  half_end;
    logic                  fall;
    logic                  wrap;
    logic                  accept;
    logic [FRAME_BITS-1:0] packed_d;
    logic [FRAME_BITS-1:0] load_w;

    assign half_end = (div_q == DIV_LAST);
    // Serial state only moves on the clk_in cycle where sck goes 1->0, so
    // sd/ws are stable for a full half period around the receiver's rising edge.
    assign fall     = half_end && sck_q;
    assign wrap     = fall && (bit_q == BIT_LAST);
    assign bit_d    = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
    // ready reflects the registered buffer state, so a boundary that empties
    // the buffer cannot bypass an incoming frame in the same cycle.
    assign accept   = valid_in && !full_q;
    // An empty buffer at a boundary transmits silence.
    assign load_w   = full_q ? buf_q : '0;

    // Pack samples into frame order: slot 0 MSB at the top, each sample
    // left-justified in its slot with zero padding below.
    always_comb begin
        packed_d = '0;
        for (int s = 0; s < SLOTS; s++) begin
            packed_d[FRAME_BITS-1-s*SLOT_BITS -: SAMPLE_BITS] = audio_in[s];
        end
    end

    // Bit clock divider; sck starts low so its first edge after reset rises.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else if (half_end) begin
            div_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            div_q <= div_q + CW'(1);
        end
    end

    // Bit counter, frame sync and serial shifter, all advanced on fall events.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_q <= BW'(FRAME_BITS - 2);
            ws_q  <= 1'b0;
            sd_q  <= 1'b0;
            sh_q  <= '0;
        end else if (fall) begin
            bit_q <= bit_d;
            ws_q  <= (bit_d == BIT_LAST);
            if (wrap) begin
                sd_q <= load_w[FRAME_BITS-1];
                sh_q <= load_w << 1;
            end else if (bit_d == BIT_LAST) begin
                // The sync period carries no data even if a slot is full width.
                sd_q <= 1'b0;
                sh_q <= sh_q << 1;
            end else begin
                sd_q <= sh_q[FRAME_BITS-1];
                sh_q <= sh_q << 1;
            end
        end
    end

    // One-frame buffer plus boundary status pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full_q <= 1'b0;
            buf_q  <= '0;
            fs_q   <= 1'b0;
            ur_q   <= 1'b0;
        end else begin
            fs_q <= wrap;
            ur_q <= wrap && !full_q;
            if (accept) begin
                full_q <= 1'b1;
                buf_q  <= packed_d;
            end else if (wrap) begin
                full_q <= 1'b0;
            end
        end
    end

    assign ready_out       = !full_q;
    assign sck_out         = sck_q;
    assign ws_out          = ws_q;
    assign sd_out          = sd_q;
    assign frame_start_out = fs_q;
    assign underrun_out    = ur_q;

endmodule
